dmadd_engine: RTL and testbench
===============================

Name: dmadd_engine

Overview:
Parametrised successor to the delta-memory scan block. It holds a DEPTH-entry signed cell memory and supports three operations on it:
- MIN: lowest non-zero index.
- MAX: highest non-zero index.
- MADD: delta-encoded histogram load with a double-prefix-sum weighted total.

It sits between the host load path and the result bus. It accepts loads while idle and runs one pointer-driven scan per run request, with a busy/done handshake.

Parameters:
DEPTH, 16, number of memory cells; AW = clog2(DEPTH)
DW, 6, signed cell width
DATA_W, 4, load data width
OUT_W, 12, result width
ACC_W, 24, signed width of the internal delta/count/total accumulators

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
index  in  AW  cell address for load
data  in  DATA_W  load operand
insn  in  2  00 MIN, 01 MAX, 10 MADD, 11 RAW
load  in  1  write request
run  in  1  scan request
busy  out  1  high while scanning
done  out  1  one-cycle pulse when out/flag are updated
flag  out  1  MIN/MAX: hit found; MADD/RAW run: result clamped
out  out  OUT_W  result, held until the next done

Behaviour:
Reset (rst=1 at an edge):
- All cells 0; state IDLE; out=0; flag=0; done=0; busy=0; accumulators 0.
- Reset overrides load/run and aborts any scan in progress.

States: IDLE -> SCAN -> DONE -> IDLE.

IDLE, load=1 (all cell arithmetic saturates to signed DW range [-2^(DW-1), 2^(DW-1)-1]):
- MIN/MAX: mem[index] <= 1.
- MADD:
  - mem[index] <= mem[index] + zext(data).
  - mem[index-1] <= mem[index-1] - zext(data).
  - At index=0 only mem[0] is updated; no wrap.
- RAW: mem[index] <= sext(data).

IDLE, run=1:
- Latch insn as mode; clear accumulators; go to SCAN.
- Pointer starts at 0 for MIN and at DEPTH-1 for MAX/MADD/RAW.
- load and run in the same cycle: the write commits, then the scan starts, and the scan sees the written value.

SCAN: one cell examined per cycle at the pointer. busy=1. load and run are ignored.
- MIN: mem[ptr]!=0 -> latch ptr as hit, go to DONE. Otherwise ptr+1. After ptr=DEPTH-1 with no hit -> DONE, no hit.
- MAX: same as MIN, with ptr-1 and terminating at ptr=0.
- MADD/RAW: each cycle, in sequence using the new values:
  - delta += sext(mem[ptr])
  - count += delta
  - total += count
  - ptr-1; after ptr=0 -> DONE. Always exactly DEPTH cycles.
- Accumulators are signed ACC_W and wrap silently; ACC_W must be sized to avoid this.

DONE (exactly one cycle): done=1, busy=0; next state IDLE.
- MIN/MAX:
  - Hit: out=zext(ptr), flag=1.
  - No hit: out=0, flag=0.
- MADD/RAW: out=clamp(total, 0, 2^OUT_W-1); flag=1 iff clamping occurred.
- load and run are ignored in DONE.

Latency (run accepted at cycle T, SCAN starts at T+1):
- MIN/MAX with the hit at scan step k (1-based): done at T+k+1.
- Full scan: done at T+DEPTH+1.

Test Plan:
1. Reset; MIN loads index 5 and index 9; run MIN at T -> done at T+7, out=5, flag=1, busy high T+1..T+6.
2. Same memory, run MAX at T -> done at T+8, out=9, flag=1.
3. Reset; run MIN on empty memory at T -> done at T+17, out=0, flag=0.
4. Reset; MADD load index=3 data=2 (mem[3]=2, mem[2]=-2); run MADD at T -> done at T+17, out=8, flag=0.
5. Saturation:
   - Reset; three MADD loads index=3 data=15 -> mem[3]=31, mem[2]=-32.
   - Reset; RAW load index=0 data=4'hF (mem[0]=-1); run RAW -> out=0, flag=1.
6. Mid-run behaviour:
   - Start MADD scan; assert load index=7 data=3 at T+4 -> no write, and a later MIN run reports no hit at 7.
   - Start a scan; assert rst at T+5 -> next cycle busy=0, done=0, out=0, all cells 0, and no done pulse follows.

Source files
------------

// File: rtl/dmadd_engine.sv
// dmadd_engine: DEPTH-cell signed delta memory with MIN/MAX index scans and a
// double-prefix-sum weighted total (MADD/RAW), examining one cell per cycle.
module dmadd_engine #(
  parameter int DEPTH  = 16,
  parameter int DW     = 6,
  parameter int DATA_W = 4,
  parameter int OUT_W  = 12,
  parameter int ACC_W  = 24,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     index,
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        insn,
  input  logic              load,
  input  logic              run,
  output logic              busy,
  output logic              done,
  output logic              flag,
  output logic [OUT_W-1:0]  out
);

  localparam int SW = ((DW > DATA_W) ? DW : DATA_W) + 2;
  localparam logic [AW-1:0] PTR_FIRST = '0;
  localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic signed [DW-1:0] CELL_ONE = DW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_MIN  = 2'b00,
    OP_MAX  = 2'b01,
    OP_MADD = 2'b10,
    OP_RAW  = 2'b11
  } op_t;

  function automatic logic signed [SW-1:0] ext_cell(input logic signed [DW-1:0] c);
    ext_cell = $signed({{(SW-DW){c[DW-1]}}, c});
  endfunction

  function automatic logic signed [ACC_W-1:0] ext_acc(input logic signed [DW-1:0] c);
    ext_acc = $signed({{(ACC_W-DW){c[DW-1]}}, c});
  endfunction

  // Saturate a widened cell value back into the signed DW range.
  function automatic logic signed [DW-1:0] sat_cell(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] cmax;
    logic signed [SW-1:0] cmin;
    cmax = $signed({{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}});
    cmin = $signed({{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}});
    if (v > cmax) begin
      sat_cell = cmax[DW-1:0];
    end else if (v < cmin) begin
      sat_cell = cmin[DW-1:0];
    end else begin
      sat_cell = v[DW-1:0];
    end
  endfunction

  // Returns {clamped, value} with value limited to [0, 2^OUT_W-1].
  function automatic logic [OUT_W:0] clamp_total(input logic signed [ACC_W-1:0] t);
    logic signed [ACC_W-1:0] omax;
    omax = $signed({{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}});
    if (t[ACC_W-1] == 1'b1) begin
      clamp_total = {1'b1, {OUT_W{1'b0}}};
    end else if (t > omax) begin
      clamp_total = {1'b1, {OUT_W{1'b1}}};
    end else begin
      clamp_total = {1'b0, t[OUT_W-1:0]};
    end
  endfunction

  state_t                  state_r;
  op_t                     mode_r;
  logic [AW-1:0]           ptr_r;
  logic signed [ACC_W-1:0] delta_r;
  logic signed [ACC_W-1:0] count_r;
  logic signed [ACC_W-1:0] total_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    flag_r;
  logic [OUT_W-1:0]        out_r;
  logic signed [DW-1:0]    mem_r [DEPTH];

  logic                    index_ok_s;
  logic [AW-1:0]           idx_m1_s;
  logic signed [SW-1:0]    data_z_s;
  logic signed [DW-1:0]    madd_hi_s;
  logic signed [DW-1:0]    madd_lo_s;
  logic signed [DW-1:0]    raw_s;
  logic signed [DW-1:0]    cell_s;
  logic                    cell_nz_s;
  logic signed [ACC_W-1:0] delta_n_s;
  logic signed [ACC_W-1:0] count_n_s;
  logic signed [ACC_W-1:0] total_n_s;
  logic [OUT_W:0]          clamp_s;

  if ((1 << AW) == DEPTH) begin : g_pow2
    assign index_ok_s = 1'b1;
  end else begin : g_npow2
    assign index_ok_s = ({1'b0, index} < (AW+1)'(DEPTH));
  end

  // Saturated cell values a load would write this cycle.
  always_comb begin
    idx_m1_s  = index - PTR_ONE;
    data_z_s  = $signed({{(SW-DATA_W){1'b0}}, data});
    madd_hi_s = sat_cell(ext_cell(mem_r[index]) + data_z_s);
    madd_lo_s = sat_cell(ext_cell(mem_r[idx_m1_s]) - data_z_s);
    raw_s     = $signed({{(DW-DATA_W){data[DATA_W-1]}}, data});
  end

  // Next accumulator values for the cell under the pointer.
  always_comb begin
    cell_s    = mem_r[ptr_r];
    cell_nz_s = (cell_s != '0);
    delta_n_s = delta_r + ext_acc(cell_s);
    count_n_s = count_r + delta_n_s;
    total_n_s = total_r + count_n_s;
    clamp_s   = clamp_total(total_n_s);
  end

  // Control FSM, memory writes, accumulators and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      mode_r  <= OP_MIN;
      ptr_r   <= PTR_FIRST;
      delta_r <= '0;
      count_r <= '0;
      total_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      flag_r  <= 1'b0;
      out_r   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (load && index_ok_s) begin
            case (op_t'(insn))
              OP_MIN, OP_MAX: mem_r[index] <= CELL_ONE;
              OP_MADD: begin
                mem_r[index] <= madd_hi_s;
                if (index != PTR_FIRST) begin
                  mem_r[idx_m1_s] <= madd_lo_s;
                end
              end
              OP_RAW:  mem_r[index] <= raw_s;
              default: mem_r[index] <= mem_r[index];
            endcase
          end
          if (run) begin
            mode_r  <= op_t'(insn);
            ptr_r   <= (op_t'(insn) == OP_MIN) ? PTR_FIRST : PTR_LAST;
            delta_r <= '0;
            count_r <= '0;
            total_r <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          case (mode_r)
            OP_MIN: begin
              if (cell_nz_s || (ptr_r == PTR_LAST)) begin
                out_r   <= cell_nz_s ? OUT_W'(ptr_r) : '0;
                flag_r  <= cell_nz_s;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                state_r <= ST_DONE;
              end else begin
                ptr_r <= ptr_r + PTR_ONE;
              end
            end
            OP_MAX: begin
              if (cell_nz_s || (ptr_r == PTR_FIRST)) begin
                out_r   <= cell_nz_s ? OUT_W'(ptr_r) : '0;
                flag_r  <= cell_nz_s;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                state_r <= ST_DONE;
              end else begin
                ptr_r <= ptr_r - PTR_ONE;
              end
            end
            default: begin
              // MADD and RAW share the full-depth weighted scan.
              delta_r <= delta_n_s;
              count_r <= count_n_s;
              total_r <= total_n_s;
              if (ptr_r == PTR_FIRST) begin
                out_r   <= clamp_s[OUT_W-1:0];
                flag_r  <= clamp_s[OUT_W];
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                state_r <= ST_DONE;
              end else begin
                ptr_r <= ptr_r - PTR_ONE;
              end
            end
          endcase
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign flag = flag_r;
  assign out  = out_r;

endmodule

// File: tb/tb_dmadd_engine.sv
// Bench for dmadd_engine: vector table, hand-written corner sequences and
// random load/run traffic checked against an arithmetic reference model.
module tb_dmadd_engine;

  localparam int DEPTH  = 16;
  localparam int DW     = 6;
  localparam int DATA_W = 4;
  localparam int OUT_W  = 12;
  localparam int ACC_W  = 24;
  localparam int AW     = 4;
  localparam int BUDGET = 40;
  localparam int OMAX   = (1 << OUT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     index;
  logic [DATA_W-1:0] data;
  logic [1:0]        insn;
  logic              load;
  logic              run;
  logic              busy;
  logic              done;
  logic              flag;
  logic [OUT_W-1:0]  out;

  int errors = 0;
  int checks = 0;
  int model_mem[DEPTH];

  always #5 clk = ~clk;

  dmadd_engine #(.DEPTH(DEPTH), .DW(DW), .DATA_W(DATA_W), .OUT_W(OUT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .index(index), .data(data), .insn(insn),
    .load(load), .run(run), .busy(busy), .done(done), .flag(flag), .out(out)
  );

  typedef struct {
    bit         do_load;
    logic [1:0] lins;
    int         idx;
    int         dat;
    logic [1:0] rins;
    int         eout;
    int         eflag;
    int         elat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  function automatic int sat(input int v);
    if (v > 31) return 31;
    if (v < -32) return -32;
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;
  endfunction

  function automatic void model_load(input logic [1:0] op, input int idx, input int d);
    case (op)
      2'b00, 2'b01: model_mem[idx] = 1;
      2'b10: begin
        model_mem[idx] = sat(model_mem[idx] + d);
        if (idx > 0) model_mem[idx-1] = sat(model_mem[idx-1] - d);
      end
      default: model_mem[idx] = (d >= 8) ? d - 16 : d;
    endcase
  endfunction

  // Each cell's contribution to the double prefix sum is weighted (i+1)(i+2)/2.
  function automatic void model_expect(input logic [1:0] op, output int eo, output int ef, output int el);
    longint total;
    eo = 0; ef = 0; el = DEPTH + 1;
    if (op == 2'b00) begin
      for (int i = 0; i < DEPTH; i++)
        if (model_mem[i] != 0) begin eo = i; ef = 1; el = i + 2; break; end
    end else if (op == 2'b01) begin
      for (int i = DEPTH - 1; i >= 0; i--)
        if (model_mem[i] != 0) begin eo = i; ef = 1; el = DEPTH - i + 1; break; end
    end else begin
      total = 0;
      for (int i = 0; i < DEPTH; i++) total += longint'(model_mem[i]) * (i + 1) * (i + 2) / 2;
      if (total < 0) begin eo = 0; ef = 1; end
      else if (total > OMAX) begin eo = OMAX; ef = 1; end
      else begin eo = int'(total); ef = 0; end
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic do_load(input logic [1:0] op, input int idx, input int d);
    insn = op; index = AW'(idx); data = DATA_W'(d); load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    model_load(op, idx, d);
  endtask

  // Issue a run, count cycles to done, watch busy, then confirm done is a single pulse.
  task automatic run_op(input string name, input logic [1:0] op, output int lat,
                        output int o, output int f);
    bit busy_ok;
    insn = op; run = 1'b1; lat = -1; o = 0; f = 0; busy_ok = 1'b1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      run = 1'b0; load = 1'b0;
      if (done === 1'b1) begin
        lat = c; o = int'(out); f = int'(flag);
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end else if (busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
    chk({name, "_busy"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic check_run(input string name, input logic [1:0] op);
    int lat, o, f, eo, ef, el;
    model_expect(op, eo, ef, el);
    run_op(name, op, lat, o, f);
    chk({name, "_out"}, o, eo);
    chk({name, "_flag"}, f, ef);
    chk({name, "_lat"}, lat, el);
  endtask

  vec_t vt[15];

  initial begin
    int lat, o, f, seen, nl;
    logic [1:0] op;

    vt[0]  = '{1'b1, 2'b00,  5,  0, 2'b00,   5, 1,  7};
    vt[1]  = '{1'b1, 2'b00,  9,  0, 2'b01,   9, 1,  8};
    vt[2]  = '{1'b1, 2'b00,  0,  0, 2'b00,   0, 1,  2};
    vt[3]  = '{1'b1, 2'b00, 15,  0, 2'b01,  15, 1,  2};
    vt[4]  = '{1'b1, 2'b01, 15,  0, 2'b00,  15, 1, 17};
    vt[5]  = '{1'b1, 2'b01,  0,  0, 2'b01,   0, 1, 17};
    vt[6]  = '{1'b1, 2'b10,  3,  2, 2'b10,   8, 0, 17};
    vt[7]  = '{1'b1, 2'b11,  0, 15, 2'b11,   0, 1, 17};
    vt[8]  = '{1'b1, 2'b11, 15,  7, 2'b11, 952, 0, 17};
    vt[9]  = '{1'b1, 2'b10,  0, 15, 2'b10,  15, 0, 17};
    vt[10] = '{1'b1, 2'b11,  4,  8, 2'b01,   4, 1, 13};
    vt[11] = '{1'b0, 2'b00,  0,  0, 2'b00,   0, 0, 17};
    vt[12] = '{1'b0, 2'b00,  0,  0, 2'b01,   0, 0, 17};
    vt[13] = '{1'b1, 2'b10,  5,  3, 2'b11,  18, 0, 17};
    vt[14] = '{1'b1, 2'b10,  1,  1, 2'b00,   0, 1,  2};

    rst = 1'b1; load = 1'b0; run = 1'b0; insn = 2'b00; index = '0; data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_flag", 32'(flag), 32'd0);

    for (int v = 0; v < 15; v++) begin
      do_reset();
      if (vt[v].do_load) do_load(vt[v].lins, vt[v].idx, vt[v].dat);
      run_op($sformatf("vec%0d", v), vt[v].rins, lat, o, f);
      chk($sformatf("vec%0d_out", v), o, vt[v].eout);
      chk($sformatf("vec%0d_flag", v), f, vt[v].eflag);
      chk($sformatf("vec%0d_lat", v), lat, vt[v].elat);
    end

    // Two hits: MIN finds the lower, MAX the higher, memory unchanged between runs.
    do_reset();
    do_load(2'b00, 5, 0);
    do_load(2'b00, 9, 0);
    run_op("two_min", 2'b00, lat, o, f);
    chk("two_min_out", o, 5); chk("two_min_lat", lat, 7);
    run_op("two_max", 2'b01, lat, o, f);
    chk("two_max_out", o, 9); chk("two_max_flag", f, 1); chk("two_max_lat", lat, 8);

    // Cell saturation: mem[3]=31, mem[2]=-32 gives 31*10 - 32*6.
    do_reset();
    repeat (3) do_load(2'b10, 3, 15);
    run_op("sat", 2'b10, lat, o, f);
    chk("sat_out", o, 118); chk("sat_flag", f, 0);

    do_reset();
    for (int i = 10; i < 16; i++) do_load(2'b11, i, 7);
    run_op("clamp_hi", 2'b11, lat, o, f);
    chk("clamp_hi_out", o, OMAX); chk("clamp_hi_flag", f, 1);

    // Load and run in the same cycle: the scan must see the new cell.
    do_reset();
    index = AW'(3); data = '0; load = 1'b1;
    model_load(2'b00, 3, 0);
    run_op("ld_run", 2'b00, lat, o, f);
    chk("ld_run_out", o, 3); chk("ld_run_lat", lat, 5);

    // A load during a scan is dropped.
    do_reset();
    insn = 2'b10; run = 1'b1;
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    insn = 2'b10; index = AW'(7); data = DATA_W'(3); load = 1'b1;
    @(negedge clk); load = 1'b0;
    chk("midload_busy", 32'(busy), 32'd1);
    seen = 0;
    for (int c = 0; c < BUDGET && seen == 0; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        chk("midload_out", 32'(out), 32'd0);
        chk("midload_flag", 32'(flag), 32'd0);
      end
    end
    chk("midload_done_seen", seen, 1);
    @(negedge clk);
    check_run("midload_min", 2'b00);

    // Reset in mid-scan clears everything and no done follows.
    do_reset();
    do_load(2'b11, 6, 5);
    check_run("prerst", 2'b11);
    insn = 2'b11; run = 1'b1;
    @(negedge clk); run = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_clear();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_out", 32'(out), 32'd0);
    chk("midrst_flag", 32'(flag), 32'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("midrst_no_done", seen, 0);
    check_run("midrst_min", 2'b00);
    check_run("midrst_raw", 2'b11);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) do_reset();
      nl = $urandom_range(0, 4);
      for (int k = 0; k < nl; k++)
        do_load(2'($urandom_range(0, 3)), $urandom_range(0, DEPTH - 1), $urandom_range(0, 15));
      op = 2'($urandom_range(0, 3));
      check_run($sformatf("rnd%0d", it), op);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
